// File: rtl/boot_rom_arbiter_if.sv
// Bus bundle between the boot ROM arbiter, its requesting masters and the ROM macro.
//  mst_req/mst_we/mst_addr  : per-master request, write enable, 32-bit byte address
//                             (master m uses mst_addr[32*m+31:32*m])
//  mst_gnt/mst_rvalid       : per-master grant and response valid (one-hot or zero)
//  mst_rdata/mst_err        : per-master read data lane and error flag
//  rom_csn/rom_addr         : ROM chip select (active-low) and word address
//  rom_rdata                : ROM read data, valid the cycle after rom_csn=0
// The slave modport is the arbiter side; the master modport is the environment
// side (masters plus ROM macro).
interface boot_rom_arbiter_if #(
  parameter int unsigned N_MST          = 2,
  parameter int unsigned ROM_ADDR_WIDTH = 13
);
  logic [N_MST-1:0]        mst_req;
  logic [N_MST-1:0]        mst_we;
  logic [N_MST*32-1:0]     mst_addr;
  logic [N_MST-1:0]        mst_gnt;
  logic [N_MST-1:0]        mst_rvalid;
  logic [N_MST*32-1:0]     mst_rdata;
  logic [N_MST-1:0]        mst_err;
  logic                    rom_csn;
  logic [ROM_ADDR_WIDTH-3:0] rom_addr;
  logic [31:0]             rom_rdata;

  modport slave (
    input  mst_req, mst_we, mst_addr, rom_rdata,
    output mst_gnt, mst_rvalid, mst_rdata, mst_err, rom_csn, rom_addr
  );

  modport master (
    output mst_req, mst_we, mst_addr, rom_rdata,
    input  mst_gnt, mst_rvalid, mst_rdata, mst_err, rom_csn, rom_addr
  );
endinterface

// File: rtl/boot_rom_arbiter.sv
// Round-robin arbiter sharing a single-port boot ROM between N_MST masters.
// Grant is combinational in the request cycle; the response (rvalid, err, owner)
// is registered and appears exactly one cycle later, overlapping the next grant.
// Writes and out-of-range addresses get an error response without touching the ROM.
// Ports:
//  clk_i  : clock
//  rst_i  : synchronous reset, active-high
//  bus    : boot_rom_arbiter_if.slave (master handshakes plus ROM macro port)
module boot_rom_arbiter #(
  parameter int unsigned N_MST          = 2,
  parameter int unsigned ROM_ADDR_WIDTH = 13
) (
  input logic               clk_i,
  input logic               rst_i,
  boot_rom_arbiter_if.slave bus
);

  localparam int unsigned IdxW  = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int unsigned WordW = ROM_ADDR_WIDTH - 2;

  logic [IdxW-1:0]  rr_q, rr_d;
  logic [IdxW-1:0]  win_idx;
  logic             win_found;
  int unsigned      cand;
  logic [31:0]      win_addr;
  logic             win_we;
  logic             win_err;
  logic             grant_ok;
  logic             rd_en;
  logic [N_MST-1:0] gnt;
  logic [WordW-1:0] rom_addr_q, rom_addr_d;
  logic             rsp_valid_q;
  logic [IdxW-1:0]  rsp_owner_q;
  logic             rsp_err_q;
  logic             unused_byte_ofs;

  // Search rr_q, rr_q+1, ... (mod N_MST) for the first requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N_MST; k++) begin
      cand = (32'(rr_q) + k) % N_MST;
      if (!win_found && bus.mst_req[IdxW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(cand);
      end
    end
  end

  assign win_addr = bus.mst_addr[32*win_idx +: 32];
  assign win_we   = bus.mst_we[win_idx];
  // Anything above the ROM window, or any write, is answered with an error.
  assign win_err  = win_we || (win_addr[31:ROM_ADDR_WIDTH] != '0);

  // Reset suppresses grants so nothing is accepted that would later be dropped.
  assign grant_ok = win_found && !rst_i;
  assign rd_en    = grant_ok && !win_err;
  assign gnt      = grant_ok ? (N_MST'(1) << win_idx) : '0;

  // Byte offset is ignored: accesses are word-aligned.
  assign unused_byte_ofs = ^win_addr[1:0];

  always_comb begin
    rr_d = rr_q;
    if (grant_ok) begin
      rr_d = (win_idx == IdxW'(N_MST - 1)) ? '0 : win_idx + IdxW'(1);
    end
  end

  // ROM address holds its last value whenever the ROM is not enabled.
  assign rom_addr_d = rd_en ? win_addr[ROM_ADDR_WIDTH-1:2] : rom_addr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      rom_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      rom_addr_q  <= rom_addr_d;
      rsp_valid_q <= grant_ok;
      rsp_owner_q <= win_idx;
      rsp_err_q   <= win_err;
    end
  end

  assign bus.mst_gnt  = gnt;
  assign bus.rom_csn  = ~rd_en;
  assign bus.rom_addr = rom_addr_d;

  // Response lane: data comes straight from the ROM output, which is valid the
  // cycle after the enable. A reset in the response cycle kills the response.
  always_comb begin
    bus.mst_rvalid = '0;
    bus.mst_err    = '0;
    bus.mst_rdata  = '0;
    if (rsp_valid_q && !rst_i) begin
      bus.mst_rvalid[rsp_owner_q] = 1'b1;
      bus.mst_err[rsp_owner_q]    = rsp_err_q;
      if (!rsp_err_q) begin
        bus.mst_rdata[32*rsp_owner_q +: 32] = bus.rom_rdata;
      end
    end
  end

  gnt_onehot0_a: assert property (@(posedge clk_i) $onehot0(bus.mst_gnt));
  rvalid_onehot0_a: assert property (@(posedge clk_i) $onehot0(bus.mst_rvalid));
  csn_needs_gnt_a: assert property (@(posedge clk_i) !bus.rom_csn |-> (bus.mst_gnt != '0));

endmodule

// File: tb/tb_boot_rom_arbiter.sv
module tb_boot_rom_arbiter;
  localparam int N  = 3;
  localparam int AW = 13;
  localparam int WW = AW - 2;

  logic clk;
  logic rst;
  logic [N-1:0] req_v;
  logic [N-1:0] we_v;
  logic [31:0]  addr_v [N];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  int           m_rr;
  bit           m_pend;
  int           m_owner;
  bit           m_perr;
  logic [WW-1:0] m_pword;
  logic [WW-1:0] m_last_addr;
  logic [N-1:0]  m_last_gnt;

  boot_rom_arbiter_if #(.N_MST(N), .ROM_ADDR_WIDTH(AW)) bus ();

  boot_rom_arbiter #(.N_MST(N), .ROM_ADDR_WIDTH(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  assign bus.mst_req = req_v;
  assign bus.mst_we  = we_v;
  for (genvar g = 0; g < N; g++) begin : g_addr
    assign bus.mst_addr[32*g +: 32] = addr_v[g];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [WW-1:0] wa);
    return 32'hC0DE_0000 ^ (32'(wa) * 32'h9E37_79B1);
  endfunction

  // ROM macro: registered read, output holds when not enabled.
  initial begin
    bus.rom_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      if (!bus.rom_csn) bus.rom_rdata <= rom_word(bus.rom_addr);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned p;
    p = $urandom_range(0, 9);
    if (p < 6)       return {19'h0, 13'($urandom)};
    else if (p == 6) return 32'h1FFC | 32'($urandom_range(0, 3));
    else if (p == 7) return 32'h2000;
    else if (p == 8) return $urandom;
    else             return 32'h1FFC;
  endfunction

  // Behavioural model and per-cycle compare.
  initial begin : model
    int win;
    int idx;
    logic bad;
    logic [N-1:0] eg, erv, eer;
    logic [N*32-1:0] erd;
    logic ecsn;
    logic [WW-1:0] ea;
    logic [31:0] wa;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_gnt", bus.mst_gnt, '0);
        chk("rst_rvalid", bus.mst_rvalid, '0);
        chk("rst_err", bus.mst_err, '0);
        chk("rst_rdata", bus.mst_rdata, '0);
        chk("rst_csn", bus.rom_csn, 1);
        m_rr = 0;
        m_pend = 0;
        m_last_addr = '0;
        m_last_gnt = '0;
      end else begin
        erv = '0; eer = '0; erd = '0;
        if (m_pend) begin
          erv[m_owner] = 1'b1;
          eer[m_owner] = m_perr;
          if (!m_perr) erd[32*m_owner +: 32] = rom_word(m_pword);
        end
        win = -1;
        for (int k = 0; k < N; k++) begin
          idx = (m_rr + k) % N;
          if (win < 0 && req_v[idx]) win = idx;
        end
        eg = '0; ecsn = 1'b1; ea = m_last_addr; bad = 1'b0; wa = '0;
        if (win >= 0) begin
          eg[win] = 1'b1;
          wa = addr_v[win];
          bad = we_v[win] || (wa >= (32'd1 << AW));
          if (!bad) begin
            ecsn = 1'b0;
            ea = WW'(wa / 4);
          end
        end
        chk("gnt", bus.mst_gnt, eg);
        chk("csn", bus.rom_csn, ecsn);
        chk("rom_addr", bus.rom_addr, ea);
        chk("rvalid", bus.mst_rvalid, erv);
        chk("err", bus.mst_err & erv, eer);
        chk("rdata", bus.mst_rdata, erd);
        m_pend = (win >= 0);
        m_owner = (win >= 0) ? win : 0;
        m_perr = bad;
        m_pword = WW'(wa / 4);
        if (win >= 0) m_rr = (win + 1) % N;
        m_last_addr = ea;
        m_last_gnt = eg;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] t6_req [6];
  logic [N-1:0] t6_gnt [6];

  initial begin
    rst = 1'b1;
    req_v = '0;
    we_v = '0;
    for (int m = 0; m < N; m++) addr_v[m] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Out-of-range read
    req_v = 3'b001; addr_v[0] = 32'h1000_0000;
    @(negedge clk);
    chk("t1_gnt", bus.mst_gnt, 3'b001);
    chk("t1_csn", bus.rom_csn, 1);
    cyc(); req_v = '0;
    @(negedge clk);
    chk("t1_rvalid", bus.mst_rvalid, 3'b001);
    chk("t1_err", bus.mst_err, 3'b001);
    chk("t1_rdata", bus.mst_rdata, '0);
    chk("t1_csn2", bus.rom_csn, 1);

    // Write attempt
    cyc(); req_v = 3'b001; we_v = 3'b001; addr_v[0] = 32'h10;
    @(negedge clk);
    chk("t4_gnt", bus.mst_gnt, 3'b001);
    chk("t4_csn", bus.rom_csn, 1);
    cyc(); req_v = '0; we_v = '0;
    @(negedge clk);
    chk("t4_rvalid", bus.mst_rvalid, 3'b001);
    chk("t4_err", bus.mst_err, 3'b001);
    chk("t4_rdata", bus.mst_rdata, '0);
    chk("t4_csn2", bus.rom_csn, 1);

    // m1 back-to-back reads including last word
    cyc(); req_v = 3'b010; addr_v[1] = 32'h4;
    @(negedge clk);
    chk("t3_gnt", bus.mst_gnt, 3'b010);
    chk("t3_csn", bus.rom_csn, 0);
    chk("t3_a0", bus.rom_addr, 11'h001);
    cyc(); addr_v[1] = 32'h8;
    @(negedge clk);
    chk("t3_a1", bus.rom_addr, 11'h002);
    chk("t3_rv0", bus.mst_rvalid, 3'b010);
    chk("t3_d0", bus.mst_rdata[63:32], rom_word(11'h001));
    cyc(); addr_v[1] = 32'h1FFC;
    @(negedge clk);
    chk("t3_a2", bus.rom_addr, 11'h7FF);
    chk("t3_rv1", bus.mst_rvalid, 3'b010);
    chk("t3_d1", bus.mst_rdata[63:32], rom_word(11'h002));
    cyc(); req_v = '0;
    @(negedge clk);
    chk("t3_rv2", bus.mst_rvalid, 3'b010);
    chk("t3_d2", bus.mst_rdata[63:32], rom_word(11'h7FF));
    chk("t3_err2", bus.mst_err, '0);
    chk("t3_hold", bus.rom_addr, 11'h7FF);

    // Two masters from reset alternate
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; req_v = 3'b011; addr_v[0] = 32'h100; addr_v[1] = 32'h204;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_gnt", bus.mst_gnt, (i % 2) ? 3'b010 : 3'b001);
      if (i > 0) begin
        chk("t2_rv", bus.mst_rvalid, (i % 2) ? 3'b001 : 3'b010);
        if (i % 2) chk("t2_d0", bus.mst_rdata[31:0], rom_word(11'h040));
        else       chk("t2_d1", bus.mst_rdata[63:32], rom_word(11'h081));
      end
      cyc();
    end
    req_v = '0;
    @(negedge clk);
    chk("t2_rv_last", bus.mst_rvalid, 3'b010);

    // Reset while a response is due
    cyc(); req_v = 3'b001; addr_v[0] = 32'h40;
    @(negedge clk);
    chk("t5_gnt", bus.mst_gnt, 3'b001);
    cyc(); rst = 1'b1; req_v = '0;
    @(negedge clk);
    chk("t5_rv_n1", bus.mst_rvalid, '0);
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("t5_rv_n2", bus.mst_rvalid, '0);
    cyc(); req_v = 3'b011;
    @(negedge clk);
    chk("t5_gnt_rr0", bus.mst_gnt, 3'b001);
    cyc(); req_v = '0;

    // Three masters, m1 drops after its first grant
    t6_req = '{3'b111, 3'b111, 3'b101, 3'b101, 3'b101, 3'b101};
    t6_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
    rst = 1'b1;
    cyc(); rst = 1'b0;
    addr_v[0] = 32'h10; addr_v[1] = 32'h20; addr_v[2] = 32'h30;
    for (int i = 0; i < 6; i++) begin
      req_v = t6_req[i];
      @(negedge clk);
      chk("t6_gnt", bus.mst_gnt, t6_gnt[i]);
      cyc();
    end
    req_v = '0;

    // Randomized traffic; masters hold until granted, occasionally give up.
    for (int c = 0; c < 3000; c++) begin
      cyc();
      rst = ($urandom_range(0, 199) == 0);
      for (int m = 0; m < N; m++) begin
        if (!(req_v[m] && !m_last_gnt[m] && $urandom_range(0, 19) != 0)) begin
          req_v[m]  = ($urandom_range(0, 99) < 60);
          we_v[m]   = ($urandom_range(0, 9) == 0);
          addr_v[m] = rand_addr();
        end
      end
    end
    cyc(); rst = 1'b0; req_v = '0; we_v = '0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
